// File: rtl/alu_seq_pkg.sv
// Register map offsets and shared types for the bus-mapped sequential ALU.
// Offsets are relative to the instance's BASE_ADDR.
package alu_seq_pkg;

    localparam int unsigned WINDOW_WORDS = 16;
    localparam int unsigned OFF_W        = 4;

    // Write map
    localparam logic [OFF_W-1:0] ALU_OP1  = 4'd0;
    localparam logic [OFF_W-1:0] ALU_OP2  = 4'd1;
    localparam logic [OFF_W-1:0] ALU_CTRL = 4'd2;

    // Read map
    localparam logic [OFF_W-1:0] ALU_ADD    = 4'd0;
    localparam logic [OFF_W-1:0] ALU_SUB    = 4'd1;
    localparam logic [OFF_W-1:0] ALU_RS     = 4'd2;
    localparam logic [OFF_W-1:0] ALU_LS     = 4'd3;
    localparam logic [OFF_W-1:0] ALU_AND    = 4'd4;
    localparam logic [OFF_W-1:0] ALU_OR     = 4'd5;
    localparam logic [OFF_W-1:0] ALU_NOT    = 4'd6;
    localparam logic [OFF_W-1:0] ALU_GT     = 4'd7;
    localparam logic [OFF_W-1:0] ALU_LT     = 4'd8;
    localparam logic [OFF_W-1:0] ALU_EQ     = 4'd9;
    localparam logic [OFF_W-1:0] ALU_OV     = 4'd10;
    localparam logic [OFF_W-1:0] ALU_MUL_LO = 4'd11;
    localparam logic [OFF_W-1:0] ALU_MUL_HI = 4'd12;
    localparam logic [OFF_W-1:0] ALU_QUOT   = 4'd13;
    localparam logic [OFF_W-1:0] ALU_REM    = 4'd14;
    localparam logic [OFF_W-1:0] ALU_STATUS = 4'd15;

    localparam int unsigned CTRL_START = 0;
    localparam int unsigned CTRL_MODE  = 1;

    typedef enum logic {
        ModeMul = 1'b0,
        ModeDiv = 1'b1
    } mode_e;

    typedef enum logic {
        StIdle = 1'b0,
        StRun  = 1'b1
    } eng_state_e;

    // Iteration counter must hold the value WIDTH itself.
    function automatic int unsigned count_width(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/alu_seq_muldiv.sv
// Iterative unsigned shift-add multiplier and restoring divider, one bit per cycle.
// A hi/lo working pair is shared: product accumulator for mul, remainder/quotient for div.
module alu_seq_muldiv
    import alu_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic               i_mode,
    input  logic [WIDTH-1:0]   i_a,
    input  logic [WIDTH-1:0]   i_b,
    output logic               o_busy,
    output logic [2*WIDTH-1:0] o_product,
    output logic [WIDTH-1:0]   o_quot,
    output logic [WIDTH-1:0]   o_rem,
    output logic               o_dz
);

    localparam int unsigned CW = count_width(WIDTH);

    eng_state_e         r_state;
    eng_state_e         w_state_d;
    mode_e              r_mode;
    logic [CW-1:0]      r_count;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic [2*WIDTH-1:0] r_product;
    logic [WIDTH-1:0]   r_quot;
    logic [WIDTH-1:0]   r_rem;
    logic               r_dz;

    logic               w_accept;
    logic               w_last;

    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_mul_next;
    logic [WIDTH:0]     w_div_shift;
    logic               w_div_ge;
    logic [WIDTH-1:0]   w_div_diff;
    logic [WIDTH-1:0]   w_div_rem;
    logic [WIDTH-1:0]   w_div_quo;
    logic [WIDTH-1:0]   w_hi_next;
    logic [WIDTH-1:0]   w_lo_next;

    always_comb begin
        w_state_d = r_state;
        w_accept  = 1'b0;
        w_last    = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (i_start) begin
                    w_accept  = 1'b1;
                    w_state_d = StRun;
                end
            end
            StRun: begin
                if (r_count == CW'(1)) begin
                    w_last    = 1'b1;
                    w_state_d = StIdle;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    // Multiply: add multiplicand into the high half when the low bit is set, then shift right.
    assign w_mul_sum  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
    assign w_mul_next = {w_mul_sum, r_lo[WIDTH-1:1]};

    // Divide: shift next dividend bit into the remainder and subtract if it fits.
    // A zero divisor always "fits", which yields all-ones quotient and remainder = dividend.
    assign w_div_shift = {r_hi, r_lo[WIDTH-1]};
    assign w_div_ge    = w_div_shift >= {1'b0, r_b};
    assign w_div_diff  = w_div_shift[WIDTH-1:0] - r_b;
    assign w_div_rem   = w_div_ge ? w_div_diff : w_div_shift[WIDTH-1:0];
    assign w_div_quo   = {r_lo[WIDTH-2:0], w_div_ge};

    assign w_hi_next = (r_mode == ModeMul) ? w_mul_next[2*WIDTH-1:WIDTH] : w_div_rem;
    assign w_lo_next = (r_mode == ModeMul) ? w_mul_next[WIDTH-1:0]       : w_div_quo;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state   <= StIdle;
            r_mode    <= ModeMul;
            r_count   <= '0;
            r_b       <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_product <= '0;
            r_quot    <= '0;
            r_rem     <= '0;
            r_dz      <= 1'b0;
        end else begin
            r_state <= w_state_d;
            if (w_accept) begin
                r_mode  <= mode_e'(i_mode);
                r_b     <= i_b;
                r_hi    <= '0;
                r_lo    <= i_a;
                r_count <= CW'(WIDTH);
                r_dz    <= (mode_e'(i_mode) == ModeDiv) && (i_b == '0);
            end else if (r_state == StRun) begin
                r_hi    <= w_hi_next;
                r_lo    <= w_lo_next;
                r_count <= r_count - CW'(1);
                if (w_last) begin
                    if (r_mode == ModeMul) begin
                        r_product <= w_mul_next;
                    end else begin
                        r_quot <= w_div_quo;
                        r_rem  <= w_div_rem;
                    end
                end
            end
        end
    end

    assign o_busy    = (r_state == StRun);
    assign o_product = r_product;
    assign o_quot    = r_quot;
    assign o_rem     = r_rem;
    assign o_dz      = r_dz;

endmodule

// File: rtl/alu_seq.sv
// Bus-mapped ALU: 16-word window at BASE_ADDR with single-cycle ops, an iterative
// mul/div engine and a tristate read-data driver on the shared data bus.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int unsigned           WIDTH      = 16,
    parameter int unsigned           ADDR_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  read_en,
    input  logic [ADDR_WIDTH-1:0] read_bus,
    input  logic                  write_en,
    input  logic [ADDR_WIDTH-1:0] write_bus,
    inout  wire  [WIDTH-1:0]      data_bus
);

    logic [WIDTH-1:0]      r_op1;
    logic [WIDTH-1:0]      r_op2;
    logic [WIDTH-1:0]      r_out_buffer;
    logic                  r_out_en;

    logic [ADDR_WIDTH-1:0] w_rd_rel;
    logic [ADDR_WIDTH-1:0] w_wr_rel;
    logic                  w_rd_hit;
    logic                  w_wr_hit;
    logic [OFF_W-1:0]      w_rd_off;
    logic [OFF_W-1:0]      w_wr_off;
    logic                  w_start;

    logic [WIDTH:0]        w_add_ext;
    logic [WIDTH-1:0]      w_rd_data;

    logic                  w_busy;
    logic                  w_dz;
    logic [2*WIDTH-1:0]    w_product;
    logic [WIDTH-1:0]      w_quot;
    logic [WIDTH-1:0]      w_rem;

    // Window test by offset so the decode is independent of where BASE_ADDR sits.
    assign w_rd_rel = read_bus - BASE_ADDR;
    assign w_wr_rel = write_bus - BASE_ADDR;
    assign w_rd_hit = read_en && (w_rd_rel < ADDR_WIDTH'(WINDOW_WORDS));
    assign w_wr_hit = write_en && (w_wr_rel < ADDR_WIDTH'(WINDOW_WORDS));
    assign w_rd_off = w_rd_rel[OFF_W-1:0];
    assign w_wr_off = w_wr_rel[OFF_W-1:0];

    assign w_start = w_wr_hit && (w_wr_off == ALU_CTRL) && data_bus[CTRL_START];

    alu_seq_muldiv #(
        .WIDTH(WIDTH)
    ) u_muldiv (
        .i_clk    (clk),
        .i_reset  (reset),
        .i_start  (w_start),
        .i_mode   (data_bus[CTRL_MODE]),
        .i_a      (r_op1),
        .i_b      (r_op2),
        .o_busy   (w_busy),
        .o_product(w_product),
        .o_quot   (w_quot),
        .o_rem    (w_rem),
        .o_dz     (w_dz)
    );

    assign w_add_ext = {1'b0, r_op1} + {1'b0, r_op2};

    always_comb begin
        w_rd_data = '0;
        case (w_rd_off)
            ALU_ADD:    w_rd_data = w_add_ext[WIDTH-1:0];
            ALU_SUB:    w_rd_data = r_op1 - r_op2;
            ALU_RS:     w_rd_data = r_op1 >> 1;
            ALU_LS:     w_rd_data = r_op1 << 1;
            ALU_AND:    w_rd_data = r_op1 & r_op2;
            ALU_OR:     w_rd_data = r_op1 | r_op2;
            ALU_NOT:    w_rd_data = ~r_op1;
            ALU_GT:     w_rd_data = WIDTH'(r_op1 > r_op2);
            ALU_LT:     w_rd_data = WIDTH'(r_op1 < r_op2);
            ALU_EQ:     w_rd_data = WIDTH'(r_op1 == r_op2);
            ALU_OV:     w_rd_data = WIDTH'(w_add_ext[WIDTH]);
            ALU_MUL_LO: w_rd_data = w_product[WIDTH-1:0];
            ALU_MUL_HI: w_rd_data = w_product[2*WIDTH-1:WIDTH];
            ALU_QUOT:   w_rd_data = w_quot;
            ALU_REM:    w_rd_data = w_rem;
            ALU_STATUS: w_rd_data = WIDTH'({w_dz, w_busy});
            default:    w_rd_data = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_op1        <= '0;
            r_op2        <= '0;
            r_out_buffer <= '0;
            r_out_en     <= 1'b0;
        end else begin
            if (w_wr_hit && (w_wr_off == ALU_OP1)) begin
                r_op1 <= data_bus;
            end
            if (w_wr_hit && (w_wr_off == ALU_OP2)) begin
                r_op2 <= data_bus;
            end
            r_out_en <= w_rd_hit;
            if (w_rd_hit) begin
                r_out_buffer <= w_rd_data;
            end
        end
    end

    assign data_bus = r_out_en ? r_out_buffer : {WIDTH{1'bz}};

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: table of single-cycle op vectors plus hand sequences
// for read timing, window decode, mul/div engine timing, divide-by-zero and reset abort.
module tb_alu_seq;
    import alu_seq_pkg::*;

    localparam int unsigned W    = 16;
    localparam int unsigned AW   = 16;
    localparam logic [AW-1:0] BASE = 16'h0100;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          read_en = 1'b0;
    logic [AW-1:0] read_bus = '0;
    logic          write_en = 1'b0;
    logic [AW-1:0] write_bus = '0;
    logic          drv_en = 1'b0;
    logic [W-1:0]  drv_data = '0;
    wire  [W-1:0]  data_bus;

    int n_checks = 0;
    int n_errors = 0;

    assign data_bus = drv_en ? drv_data : {W{1'bz}};

    always #5 clk = ~clk;

    alu_seq #(
        .WIDTH     (W),
        .ADDR_WIDTH(AW),
        .BASE_ADDR (BASE)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .read_en  (read_en),
        .read_bus (read_bus),
        .write_en (write_en),
        .write_bus(write_bus),
        .data_bus (data_bus)
    );

    typedef struct {
        logic [15:0] op1;
        logic [15:0] op2;
        logic [3:0]  off;
        logic [15:0] exp;
        string       name;
    } vec_t;

    vec_t vecs [19];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // All stimulus changes happen at the falling edge; outputs are sampled there too.
    task automatic write_addr(input logic [AW-1:0] addr, input logic [W-1:0] data);
        write_en  = 1'b1;
        write_bus = addr;
        drv_en    = 1'b1;
        drv_data  = data;
        @(negedge clk);
        write_en  = 1'b0;
        drv_en    = 1'b0;
    endtask

    task automatic write_reg(input logic [3:0] off, input logic [W-1:0] data);
        write_addr(BASE + AW'(off), data);
    endtask

    task automatic read_chk(input string name, input logic [3:0] off, input logic [W-1:0] exp);
        read_en  = 1'b1;
        read_bus = BASE + AW'(off);
        @(negedge clk);
        check(name, 32'(data_bus), 32'(exp));
        read_en = 1'b0;
        @(negedge clk);
    endtask

    task automatic poll_busy(output int busy_cycles, output logic [W-1:0] last);
        busy_cycles = 0;
        last        = '0;
        read_en     = 1'b1;
        read_bus    = BASE + AW'(ALU_STATUS);
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            last = data_bus;
            if (!last[0]) break;
            busy_cycles++;
        end
        read_en = 1'b0;
        @(negedge clk);
    endtask

    task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] ctrl, input logic [W-1:0] exp_status);
        int          cyc;
        logic [W-1:0] st;
        write_reg(ALU_OP1, a);
        write_reg(ALU_OP2, b);
        write_reg(ALU_CTRL, ctrl);
        poll_busy(cyc, st);
        check({name, "_busy_cycles"}, 32'(cyc), 32'd16);
        check({name, "_status_done"}, 32'(st), 32'(exp_status));
    endtask

    initial begin
        int           cyc;
        logic [W-1:0] st;
        logic [3:0]   seq_off [5];
        logic [15:0]  seq_exp [5];

        vecs[0]  = '{16'h0005, 16'h0003, ALU_ADD, 16'h0008, "add_5_3"};
        vecs[1]  = '{16'h0005, 16'h0003, ALU_SUB, 16'h0002, "sub_5_3"};
        vecs[2]  = '{16'h0003, 16'h0005, ALU_SUB, 16'hFFFE, "sub_3_5"};
        vecs[3]  = '{16'h0005, 16'h0003, ALU_GT,  16'h0001, "gt_5_3"};
        vecs[4]  = '{16'h0003, 16'h0005, ALU_GT,  16'h0000, "gt_3_5"};
        vecs[5]  = '{16'h0003, 16'h0005, ALU_LT,  16'h0001, "lt_3_5"};
        vecs[6]  = '{16'h0007, 16'h0007, ALU_EQ,  16'h0001, "eq_7_7"};
        vecs[7]  = '{16'h0007, 16'h0008, ALU_EQ,  16'h0000, "eq_7_8"};
        vecs[8]  = '{16'h0007, 16'h0007, ALU_LT,  16'h0000, "lt_7_7"};
        vecs[9]  = '{16'hFFFF, 16'h0001, ALU_OV,  16'h0001, "ov_ffff_1"};
        vecs[10] = '{16'hFFFF, 16'h0001, ALU_ADD, 16'h0000, "add_ffff_1"};
        vecs[11] = '{16'h8000, 16'h8000, ALU_OV,  16'h0001, "ov_8000_8000"};
        vecs[12] = '{16'h7FFF, 16'h8000, ALU_OV,  16'h0000, "ov_7fff_8000"};
        vecs[13] = '{16'h7FFF, 16'h8000, ALU_ADD, 16'hFFFF, "add_7fff_8000"};
        vecs[14] = '{16'h8001, 16'h0000, ALU_RS,  16'h4000, "rs_8001"};
        vecs[15] = '{16'h8001, 16'h0000, ALU_LS,  16'h0002, "ls_8001"};
        vecs[16] = '{16'hF0F0, 16'h0FF0, ALU_AND, 16'h00F0, "and_f0f0"};
        vecs[17] = '{16'hF0F0, 16'h0FF0, ALU_OR,  16'hFFF0, "or_f0f0"};
        vecs[18] = '{16'hF0F0, 16'h0FF0, ALU_NOT, 16'h0F0F, "not_f0f0"};

        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Reset state
        check("reset_out_en", 32'(dut.r_out_en), 32'd0);
        read_chk("reset_status", ALU_STATUS, 16'h0000);
        read_chk("reset_add",    ALU_ADD,    16'h0000);
        read_chk("reset_eq",     ALU_EQ,     16'h0001);
        read_chk("reset_mul_lo", ALU_MUL_LO, 16'h0000);
        read_chk("reset_quot",   ALU_QUOT,   16'h0000);

        // Single-cycle op table
        for (int i = 0; i < 19; i++) begin
            write_reg(ALU_OP1, vecs[i].op1);
            write_reg(ALU_OP2, vecs[i].op2);
            read_chk(vecs[i].name, vecs[i].off, vecs[i].exp);
        end

        // Back-to-back reads keep the bus driven; it floats one cycle after the last.
        seq_off = '{ALU_ADD, ALU_SUB, ALU_GT, ALU_LT, ALU_OV};
        seq_exp = '{16'h0008, 16'h0002, 16'h0001, 16'h0000, 16'h0000};
        write_reg(ALU_OP1, 16'h0005);
        write_reg(ALU_OP2, 16'h0003);
        read_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            read_bus = BASE + AW'(seq_off[i]);
            @(negedge clk);
            check($sformatf("b2b_val_%0d", i), 32'(data_bus), 32'(seq_exp[i]));
            check($sformatf("b2b_drv_%0d", i), 32'(dut.r_out_en), 32'd1);
        end
        read_en = 1'b0;
        @(negedge clk);
        check("b2b_release", 32'(dut.r_out_en), 32'd0);

        // Window decode: out-of-window reads and writes are ignored.
        write_reg(ALU_OP1, 16'hFFFF);
        write_reg(ALU_OP2, 16'h0001);
        read_en  = 1'b1;
        read_bus = BASE + AW'(16);
        @(negedge clk);
        check("oow_read_above", 32'(dut.r_out_en), 32'd0);
        read_bus = BASE - AW'(1);
        @(negedge clk);
        check("oow_read_below", 32'(dut.r_out_en), 32'd0);
        read_en = 1'b0;
        @(negedge clk);
        write_addr(BASE + AW'(16), 16'h0055);
        write_addr(BASE - AW'(16), 16'h0077);
        read_chk("oow_write_ignored_ov",  ALU_OV,  16'h0001);
        read_chk("oow_write_ignored_add", ALU_ADD, 16'h0000);

        // Multiply, polled to completion
        run_op("mul_1234", 16'h1234, 16'h0100, 16'h0001, 16'h0000);
        read_chk("mul_1234_lo", ALU_MUL_LO, 16'h3400);
        read_chk("mul_1234_hi", ALU_MUL_HI, 16'h0012);

        // Divide with operand writes and a second start while running
        write_reg(ALU_OP1, 16'd100);
        write_reg(ALU_OP2, 16'd7);
        write_reg(ALU_CTRL, 16'h0003);
        read_chk("div_stale_quot", ALU_QUOT, 16'h0000);
        write_reg(ALU_OP1, 16'h0000);
        write_reg(ALU_CTRL, 16'h0003);
        poll_busy(cyc, st);
        check("div_remaining_busy", 32'(cyc), 32'd12);
        check("div_status_done",    32'(st),  32'd0);
        read_chk("div_quot", ALU_QUOT, 16'd14);
        read_chk("div_rem",  ALU_REM,  16'd2);
        read_chk("div_op1_written_add", ALU_ADD, 16'd7);
        read_chk("div_mul_lo_kept", ALU_MUL_LO, 16'h3400);

        // Divide by zero
        run_op("divz", 16'h00AB, 16'h0000, 16'h0003, 16'h0002);
        read_chk("divz_quot", ALU_QUOT, 16'hFFFF);
        read_chk("divz_rem",  ALU_REM,  16'h00AB);

        // Reset during a running multiply; the new start also clears div_by_zero.
        write_reg(ALU_OP1, 16'h1234);
        write_reg(ALU_OP2, 16'h0100);
        write_reg(ALU_CTRL, 16'h0001);
        read_chk("abort_status_running", ALU_STATUS, 16'h0001);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        read_chk("abort_status", ALU_STATUS, 16'h0000);
        read_chk("abort_mul_lo", ALU_MUL_LO, 16'h0000);
        read_chk("abort_mul_hi", ALU_MUL_HI, 16'h0000);
        read_chk("abort_quot",   ALU_QUOT,   16'h0000);
        read_chk("abort_rem",    ALU_REM,    16'h0000);
        read_chk("abort_add",    ALU_ADD,    16'h0000);

        // Engine is usable again after the abort; full-range operands.
        run_op("mul_max", 16'hFFFF, 16'hFFFF, 16'h0001, 16'h0000);
        read_chk("mul_max_lo", ALU_MUL_LO, 16'h0001);
        read_chk("mul_max_hi", ALU_MUL_HI, 16'hFFFE);
        run_op("div_max", 16'hFFFF, 16'h0010, 16'h0003, 16'h0000);
        read_chk("div_max_quot", ALU_QUOT, 16'h0FFF);
        read_chk("div_max_rem",  ALU_REM,  16'h000F);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete, %0d checks so far", n_checks);
        $fatal(1, "timeout");
    end

endmodule
